// File: rtl/bus_timer_pkg.sv
// bus_timer shared definitions: register offsets,
// control/status bit positions and reset constants.
package bus_timer_pkg;

  typedef enum logic [3:0] {
    OFF_MTIME_LO    = 4'd0,
    OFF_MTIME_HI    = 4'd1,
    OFF_MTIMECMP_LO = 4'd2,
    OFF_MTIMECMP_HI = 4'd3,
    OFF_CTRL        = 4'd4,
    OFF_STATUS      = 4'd5,
    OFF_LED         = 4'd6
  } reg_off_e;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_IE_BIT     = 1;
  localparam int STATUS_PEND_BIT = 0;
  localparam int LED_W           = 10;

  localparam logic [63:0] MTIMECMP_RST =
    64'hFFFF_FFFF_FFFF_FFFF;

  // Byte-lane merge of a 32-bit write into a register.
  function automatic logic [31:0] be_merge(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  be
  );
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/bus_timer_tick_gen.sv
// Prescaler: counts 0..Divide-1 while enabled and
// flags the wrap cycle as a one-cycle tick.
module tick_gen #(
  parameter int Divide = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (Divide > 1) ? $clog2(Divide) : 1;
  localparam logic [CW-1:0] LAST = CW'(Divide - 1);

  logic [CW-1:0] r_cnt;

  // Count enabled cycles; a clear always restarts the phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  assign tick = en && (r_cnt == LAST);

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped machine timer: 64-bit mtime/mtimecmp,
// pending/interrupt logic and a small LED register.
module bus_timer
  import bus_timer_pkg::*;
#(
  parameter int ClockFreqHz = 50_000_000,
  parameter int TickHz      = 1_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       addr,
  input  logic [31:0]      wdata,
  input  logic [3:0]       byte_en,
  input  logic             wr,
  input  logic             addr_strobe,
  output logic [31:0]      data,
  output logic             irq_o,
  output logic [LED_W-1:0] led_o
);

  localparam int Divide = ClockFreqHz / TickHz;

  logic [63:0]      r_mtime;
  logic [63:0]      r_mtimecmp;
  logic [31:0]      r_shadow;
  logic [31:0]      r_data;
  logic             r_en;
  logic             r_ie;
  logic             r_pend;
  logic             r_irq;
  logic [LED_W-1:0] r_led;

  logic        w_wr;
  logic        w_rd;
  logic        w_wr_lo;
  logic        w_wr_hi;
  logic        w_ctrl_wr;
  logic        w_pend_clr;
  logic        w_tick;
  logic        w_cmp;
  logic [31:0] w_rdata;

  assign w_wr    = addr_strobe && wr;
  assign w_rd    = addr_strobe && !wr;
  assign w_wr_lo = w_wr && (addr == OFF_MTIME_LO);
  assign w_wr_hi = w_wr && (addr == OFF_MTIME_HI);

  assign w_ctrl_wr = w_wr && (addr == OFF_CTRL)
                     && byte_en[0];
  assign w_pend_clr = w_wr && (addr == OFF_STATUS)
                      && byte_en[0]
                      && wdata[STATUS_PEND_BIT];

  assign w_cmp = (r_mtime >= r_mtimecmp);

  tick_gen #(
    .Divide(Divide)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (r_en),
    .clr (w_ctrl_wr),
    .tick(w_tick)
  );

  // mtime: a bus write to either half beats the tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mtime <= '0;
    end else if (w_wr_lo) begin
      r_mtime[31:0] <=
        be_merge(r_mtime[31:0], wdata, byte_en);
    end else if (w_wr_hi) begin
      r_mtime[63:32] <=
        be_merge(r_mtime[63:32], wdata, byte_en);
    end else if (w_tick) begin
      r_mtime <= r_mtime + 64'd1;
    end
  end

  // mtimecmp halves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mtimecmp <= MTIMECMP_RST;
    end else if (w_wr) begin
      if (addr == OFF_MTIMECMP_LO)
        r_mtimecmp[31:0] <=
          be_merge(r_mtimecmp[31:0], wdata, byte_en);
      if (addr == OFF_MTIMECMP_HI)
        r_mtimecmp[63:32] <=
          be_merge(r_mtimecmp[63:32], wdata, byte_en);
    end
  end

  // CTRL and LED registers; only implemented bits stored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en  <= 1'b0;
      r_ie  <= 1'b0;
      r_led <= '0;
    end else begin
      if (w_ctrl_wr) begin
        r_en <= wdata[CTRL_EN_BIT];
        r_ie <= wdata[CTRL_IE_BIT];
      end
      if (w_wr && (addr == OFF_LED)) begin
        if (byte_en[0]) r_led[7:0] <= wdata[7:0];
        if (byte_en[1]) r_led[9:8] <= wdata[9:8];
      end
    end
  end

  // PEND is sticky on compare; a clear wins for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= 1'b0;
      r_irq  <= 1'b0;
    end else begin
      r_pend <= w_pend_clr ? 1'b0 : (r_pend || w_cmp);
      r_irq  <= r_pend && r_ie;
    end
  end

  // Read mux.
  always_comb begin
    w_rdata = '0;
    case (addr)
      OFF_MTIME_LO:    w_rdata = r_mtime[31:0];
      OFF_MTIME_HI:    w_rdata = r_shadow;
      OFF_MTIMECMP_LO: w_rdata = r_mtimecmp[31:0];
      OFF_MTIMECMP_HI: w_rdata = r_mtimecmp[63:32];
      OFF_CTRL: begin
        w_rdata[CTRL_EN_BIT] = r_en;
        w_rdata[CTRL_IE_BIT] = r_ie;
      end
      OFF_STATUS:      w_rdata[STATUS_PEND_BIT] = r_pend;
      OFF_LED:         w_rdata[LED_W-1:0] = r_led;
      default:         w_rdata = '0;
    endcase
  end

  // Registered read data; an LO read snapshots the HI half.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data   <= '0;
      r_shadow <= '0;
    end else if (w_rd) begin
      r_data <= w_rdata;
      if (addr == OFF_MTIME_LO) r_shadow <= r_mtime[63:32];
    end
  end

  assign data  = r_data;
  assign irq_o = r_irq;
  assign led_o = r_led;

endmodule

// File: tb/tb_bus_timer.sv
// Randomized scoreboard bench for bus_timer against an
// abstract model of the timer's register behaviour.
module tb_bus_timer;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  byte_en;
  logic        wr;
  logic        addr_strobe;
  logic [31:0] data;
  logic        irq_o;
  logic [9:0]  led_o;

  always #5 clk = ~clk;

  bus_timer #(
    .ClockFreqHz(DIV),
    .TickHz     (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .wdata      (wdata),
    .byte_en    (byte_en),
    .wr         (wr),
    .addr_strobe(addr_strobe),
    .data       (data),
    .irq_o      (irq_o),
    .led_o      (led_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] v;
    logic [3:0]  a;
  } exp_t;
  exp_t q[$];

  // Model state: values the DUT should hold after the last edge.
  logic [63:0] m_mt, m_cmp;
  logic [31:0] m_shadow;
  logic        m_en, m_ie, m_pend, m_irq;
  logic [9:0]  m_led;
  int          m_ecnt;
  bit          mon_on = 1'b0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %h want %h @%0t",
                 nm, act, exp, $time);
    end
  endtask

  task automatic check_rng(input string nm,
                           input logic [31:0] act,
                           input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d..%0d",
               nm, act, lo, hi);
    end
  endtask

  function automatic logic [31:0] mrg(
    input logic [31:0] o, input logic [31:0] n,
    input logic [3:0] b);
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = b[i] ? n[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mread(input logic [3:0] a);
    case (a)
      4'd0: return m_mt[31:0];
      4'd1: return m_shadow;
      4'd2: return m_cmp[31:0];
      4'd3: return m_cmp[63:32];
      4'd4: return {30'd0, m_ie, m_en};
      4'd5: return {31'd0, m_pend};
      4'd6: return {22'd0, m_led};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_mt = '0; m_cmp = '1; m_shadow = '0;
    m_en = 0; m_ie = 0; m_pend = 0; m_irq = 0;
    m_led = '0; m_ecnt = 0;
  endtask

  // One bus cycle: drive, predict, wait for the edge, commit.
  task automatic cyc(input logic s, input logic w,
                     input logic [3:0] a,
                     input logic [31:0] d,
                     input logic [3:0] b);
    logic        rd, wq, tick;
    logic [31:0] rv, t;
    logic [63:0] n_mt, n_cmp;
    logic [31:0] n_sh;
    logic        n_en, n_ie, n_pend, n_irq;
    logic [9:0]  n_led;
    int          n_ecnt;
    addr_strobe = s; wr = w; addr = a;
    wdata = d; byte_en = b;
    rd = s && !w;
    wq = s && w;
    rv = mread(a);
    tick = m_en && (m_ecnt % DIV == DIV - 1);
    n_mt = m_mt; n_cmp = m_cmp; n_sh = m_shadow;
    n_en = m_en; n_ie = m_ie; n_led = m_led;
    if (wq && a == 4'd0)
      n_mt[31:0] = mrg(m_mt[31:0], d, b);
    else if (wq && a == 4'd1)
      n_mt[63:32] = mrg(m_mt[63:32], d, b);
    else if (tick)
      n_mt = m_mt + 64'd1;
    if (wq && a == 4'd2) n_cmp[31:0] = mrg(m_cmp[31:0], d, b);
    if (wq && a == 4'd3) n_cmp[63:32] = mrg(m_cmp[63:32], d, b);
    if (wq && a == 4'd4 && b[0]) begin
      n_en = d[0]; n_ie = d[1]; n_ecnt = 0;
    end else begin
      n_ecnt = m_en ? m_ecnt + 1 : m_ecnt;
    end
    if (wq && a == 4'd6) begin
      t = mrg({22'd0, m_led}, d, b);
      n_led = t[9:0];
    end
    if (wq && a == 4'd5 && b[0] && d[0]) n_pend = 0;
    else n_pend = m_pend || (m_mt >= m_cmp);
    n_irq = m_pend && m_ie;
    if (rd && a == 4'd0) n_sh = m_mt[63:32];
    @(posedge clk);
    m_mt = n_mt; m_cmp = n_cmp; m_shadow = n_sh;
    m_en = n_en; m_ie = n_ie; m_pend = n_pend;
    m_irq = n_irq; m_led = n_led; m_ecnt = n_ecnt;
    if (rd) q.push_back('{v: rv, a: a});
    #1;
    addr_strobe = 0; wr = 0;
  endtask

  task automatic wreg(input logic [3:0] a,
                      input logic [31:0] d);
    cyc(1, 1, a, d, 4'hF);
  endtask

  task automatic rreg(input logic [3:0] a);
    cyc(1, 0, a, 32'd0, 4'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 4'd0, 32'd0, 4'd0);
  endtask

  // Monitor: pops a read expectation after each read edge.
  initial begin
    logic rdv;
    exp_t e;
    forever begin
      @(posedge clk);
      rdv = mon_on && addr_strobe && !wr && !rst;
      @(negedge clk);
      if (mon_on) begin
        if (rdv) begin
          if (q.size() == 0) begin
            check("rd_queue_empty", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            check($sformatf("rd_off%0d", e.a), data, e.v);
          end
        end
        check("irq_o", {31'd0, irq_o}, {31'd0, m_irq});
        check("led_o", {22'd0, led_o}, {22'd0, m_led});
      end
    end
  end

  initial begin
    int found;
    logic [3:0]  a;
    logic [31:0] d;
    rst = 1; addr_strobe = 0; wr = 0; addr = 0;
    wdata = 0; byte_en = 0;
    model_reset();
    @(posedge clk); #1;
    // Strobe during reset must be discarded.
    addr_strobe = 1; wr = 1; addr = 4'd6;
    wdata = 32'h3FF; byte_en = 4'hF;
    @(posedge clk); #1;
    addr_strobe = 0; wr = 0;
    check("rst_data", data, 32'd0);
    check("rst_irq", {31'd0, irq_o}, 32'd0);
    check("rst_led", {22'd0, led_o}, 32'd0);
    rst = 0;
    mon_on = 1;

    // Reset readback of all registers.
    for (int i = 0; i < 7; i++) rreg(4'(i));
    idle(1);

    // Partial byte-enable write to LED.
    cyc(1, 1, 4'd6, 32'h3FF, 4'b0001);
    check("led_be", {22'd0, led_o}, 32'h0FF);
    rreg(4'd6);
    check("led_be_rd", data, 32'h0FF);

    // Tick rate.
    wreg(4'd4, 32'd1);
    idle(40);
    wreg(4'd4, 32'd0);
    rreg(4'd0);
    check_rng("tick_rate", data, 9, 11);
    idle(10);
    rreg(4'd0);

    // Carry and tear-free read.
    wreg(4'd0, 32'hFFFF_FFFF);
    wreg(4'd1, 32'd0);
    wreg(4'd4, 32'd1);
    idle(DIV);
    rreg(4'd0);
    rreg(4'd1);
    check("carry_hi", data, 32'd1);
    wreg(4'd0, 32'hFFFF_FFF0);
    rreg(4'd0);
    idle(10 * DIV);
    rreg(4'd1);
    check("shadow_hold", data, 32'd1);

    // Interrupt.
    wreg(4'd4, 32'd0);
    wreg(4'd0, 32'd0);
    wreg(4'd1, 32'd0);
    wreg(4'd3, 32'd0);
    wreg(4'd2, 32'd5);
    wreg(4'd4, 32'd3);
    idle(8 * DIV);
    check("irq_up", {31'd0, irq_o}, 32'd1);
    wreg(4'd5, 32'd1);
    idle(2);
    rreg(4'd5);
    check("pend_reset", data, 32'd1);
    wreg(4'd3, 32'hFFFF_FFFF);
    wreg(4'd2, 32'hFFFF_FFFF);
    wreg(4'd5, 32'd1);
    idle(3);
    check("irq_down", {31'd0, irq_o}, 32'd0);

    // Write/tick collision.
    found = 0;
    for (int i = 0; i < 2 * DIV && found == 0; i++) begin
      if (m_en && (m_ecnt % DIV == DIV - 1)) found = 1;
      else idle(1);
    end
    check("tick_sync", found, 32'd1);
    wreg(4'd0, 32'd7);
    wreg(4'd4, 32'd0);
    rreg(4'd0);
    check("collide_lo", data, 32'd7);

    // Random traffic.
    wreg(4'd4, 32'd1);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) < 6) begin
        a = ($urandom_range(0, 9) < 9) ?
            4'($urandom_range(0, 6)) :
            4'($urandom_range(7, 15));
        d = $urandom;
        if (a == 4'd1 || a == 4'd3) d = $urandom_range(0, 1);
        if (a == 4'd0 || a == 4'd2) d = $urandom_range(0, 300);
        cyc(1, 1'($urandom_range(0, 1)), a, d,
            4'($urandom_range(0, 15)));
      end else begin
        idle(1);
      end
    end

    // Async reset between edges.
    wreg(4'd6, 32'h3FF);
    wreg(4'd2, 32'd0);
    wreg(4'd3, 32'd0);
    wreg(4'd4, 32'd3);
    idle(4);
    rreg(4'd6);
    mon_on = 0;
    q.delete();
    #2;
    rst = 1;
    #1;
    check("arst_data", data, 32'd0);
    check("arst_irq", {31'd0, irq_o}, 32'd0);
    check("arst_led", {22'd0, led_o}, 32'd0);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    mon_on = 1;
    rreg(4'd2);
    rreg(4'd0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_timer.md
BUS_TIMER -- requirements
Module: bus_timer

Interface
REQ-001 The block SHALL have parameter ClockFreqHz, default 50_000_000, meaning the input clock frequency in Hz.
REQ-002 The block SHALL have parameter TickHz, default 1_000_000, meaning the mtime increment rate in Hz; ClockFreqHz/TickHz SHALL be an integer >= 1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port rst, input, 1 bit: the reset, asynchronous and active-high.
REQ-005 The block SHALL have port addr, input, 4 bits: the word offset within the block.
REQ-006 The block SHALL have port wdata, input, 32 bits: the write data.
REQ-007 The block SHALL have port byte_en, input, 4 bits: the per-byte write enables.
REQ-008 The block SHALL have port wr, input, 1 bit: 1 = write, 0 = read, qualified by addr_strobe.
REQ-009 The block SHALL have port addr_strobe, input, 1 bit: a one-cycle access request.
REQ-010 The block SHALL have port data, output, 32 bits: the registered read data.
REQ-011 The block SHALL have port irq_o, output, 1 bit: the timer interrupt, level.
REQ-012 The block SHALL have port led_o, output, 10 bits: the LED register.

Function
REQ-013 The register map SHALL use word offsets: 0 MTIME_LO, 1 MTIME_HI, 2 MTIMECMP_LO, 3 MTIMECMP_HI, 4 CTRL (bit0 EN, bit1 IE), 5 STATUS (bit0 PEND), 6 LED (bits 9:0).
- Offsets 7-15 SHALL read 0; writes to them SHALL be ignored.
REQ-014 An access SHALL occur on a cycle where addr_strobe=1; when addr_strobe=0, wr, addr, wdata and byte_en SHALL be ignored.
REQ-015 A write SHALL update each byte lane i where byte_en[i]=1 at the clock edge ending the strobe cycle; lanes with byte_en[i]=0 SHALL keep their value.
- Bits that are unimplemented in CTRL, STATUS and LED SHALL ignore writes and read 0.
REQ-016 A read SHALL present the register value on data at the edge after the strobe cycle (1-cycle latency, matching synchronous RAM).
- data SHALL hold its value until the next read strobe.
REQ-017 A prescaler SHALL count 0..ClockFreqHz/TickHz-1 while CTRL.EN=1 and emit a one-cycle tick at wrap.
- It SHALL freeze while EN=0 and clear to 0 when EN is written.
REQ-018 mtime (64-bit) SHALL increment by 1 on each tick and wrap from 2^64-1 to 0.
REQ-019 A bus write to MTIME_LO or MTIME_HI in the same cycle as a tick SHALL win; the written half takes the written value and no increment is applied that cycle.
- A carry into the other half SHALL be suppressed that cycle.
REQ-020 Reading MTIME_LO SHALL capture mtime[63:32] into a shadow register in the same cycle.
- Reading MTIME_HI SHALL return the shadow, giving a tear-free 64-bit read for an LO-then-HI read sequence.
REQ-021 STATUS.PEND SHALL be set on any cycle with mtime >= mtimecmp (unsigned 64-bit comparison), regardless of IE.
REQ-022 Writing 1 to STATUS bit0 (with byte_en[0]=1) SHALL clear PEND; if the compare is still true, PEND SHALL be set again on the next cycle.
REQ-023 irq_o SHALL be registered and equal PEND AND CTRL.IE, delayed one cycle.

Reset
REQ-024 While rst=1, asynchronously and irrespective of clk:
- mtime, shadow and prescaler SHALL be 0;
- mtimecmp SHALL be 64'hFFFF_FFFF_FFFF_FFFF;
- CTRL, STATUS and LED SHALL be 0;
- data SHALL be 0, irq_o SHALL be 0 and led_o SHALL be 0.
REQ-025 A strobe coincident with rst=1 SHALL be discarded; the first access SHALL be accepted on the first clk edge after rst deasserts.

Structure
REQ-026 A shared package bus_timer_pkg SHALL hold:
- the register-offset enum;
- CTRL and STATUS bit-position constants;
- the 64-bit mtimecmp reset constant.
REQ-027 The prescaler SHALL be a sub-module named tick_gen (parameter Divide, inputs clk/rst/en/clr, output tick).
REQ-028 The block SHALL contain no tri-state drivers; output muxing to the system bus belongs to the integrating level.

Verification
REQ-029 Reset and readback:
- Stimulus: deassert rst, then read offsets 0-6.
- Required response: data = 0,0,FFFFFFFF,FFFFFFFF,0,0,0, each one cycle after its strobe.
REQ-030 Byte enables:
- Stimulus: write LED wdata=0x3FF, byte_en=4'b0001.
- Required response: led_o=0x0FF; a following read returns 0x000000FF.
REQ-031 Tick rate:
- Stimulus: Divide=4, CTRL=1, run 40 clocks.
- Required response: mtime=10 ±1 depending on enable phase.
- Stimulus: CTRL=0.
- Required response: mtime holds.
REQ-032 Carry and tear-free read:
- Stimulus: write MTIME_LO=0xFFFFFFFF, MTIME_HI=0, enable, wait for one tick, read LO then HI.
- Required response: LO=0, HI=1.
- Stimulus: stall 10 ticks between the LO and HI reads.
- Required response: HI still equals the value captured at the LO read.
REQ-033 Interrupt:
- Stimulus: mtimecmp=5, CTRL=3.
- Required response: irq_o rises one cycle after mtime reaches 5.
- Stimulus: write STATUS=1.
- Required response: PEND re-sets (compare still true).
- Stimulus: mtimecmp=0xFFFF_FFFF_FFFF_FFFF, then STATUS=1.
- Required response: irq_o falls.
REQ-034 Write/tick collision and async reset:
- Stimulus: write MTIME_LO=7 on the tick cycle.
- Required response: MTIME_LO reads 7.
- Stimulus: assert rst mid-count, between clock edges.
- Required response: all outputs go to 0 immediately.
